// File: rtl/mem_arb_pkg.sv
// Shared state encoding and index-width helper for the memory channel arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        RD_RELAY,
        WR_RELAY
    } chan_state_t;

    // Never returns 0, so a single-consumer build still has a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_rr_picker.sv
// Combinational round-robin pick: first requester at or after i_ptr (wrapping)
// that is not in the exclude mask.
module mem_rr_picker
    import mem_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [N-1:0]  i_excl,
    input  logic [IW-1:0] i_ptr,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    int w_dist;
    int w_best;

    // The smallest wrapped distance from the pointer wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_dist  = 0;
        w_best  = N;
        for (int j = 0; j < N; j++) begin
            w_dist = (j >= int'(i_ptr)) ? (j - int'(i_ptr)) : (j + N - int'(i_ptr));
            if (i_req[j] && !i_excl[j] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_found = 1'b1;
                o_idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mem_channel_arbiter.sv
// Shares CHANNELS memory channels among CONSUMERS requesters, round-robin.
// Write path is built only when MEM_ARB_WRITE_EN is defined.
module mem_channel_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int CONSUMERS = 4,
    parameter int CHANNELS  = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [CONSUMERS-1:0]                 consumer_read_ready,
    output logic [CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [CONSUMERS-1:0]                 consumer_write_ready,
    output logic [CHANNELS-1:0]                  mem_read_valid,
    output logic [CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
    input  logic [CHANNELS-1:0]                  mem_read_ready,
    input  logic [CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
    output logic [CHANNELS-1:0]                  mem_write_valid,
    output logic [CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
    output logic [CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
    input  logic [CHANNELS-1:0]                  mem_write_ready,
    output logic                                 busy
);

    localparam int IDX_W = idx_width(CONSUMERS);

    logic [CONSUMERS-1:0] w_any_req;
    logic [CONSUMERS-1:0] w_owned;
    logic [CHANNELS-1:0]  w_busy;
    logic [CHANNELS-1:0]  w_rd_relay;
    logic [CHANNELS-1:0]  w_grant;
    logic [IDX_W-1:0]     w_owner     [CHANNELS];
    logic [IDX_W-1:0]     w_grant_idx [CHANNELS];
    logic [DATA_BITS-1:0] w_rdata     [CHANNELS];
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [IDX_W-1:0]     w_ptr_next;

`ifdef MEM_ARB_WRITE_EN
    logic [CHANNELS-1:0]  w_wr_relay;
    assign w_any_req = consumer_read_valid | consumer_write_valid;
`else
    logic w_unused_wr;
    assign w_any_req   = consumer_read_valid;
    assign w_unused_wr = ^{consumer_write_valid, consumer_write_address,
                           consumer_write_data, mem_write_ready};
    assign mem_write_valid   = '0;
    assign mem_write_address = '0;
    assign mem_write_data    = '0;
`endif

    always_comb begin
        w_owned = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_busy[c]) w_owned[w_owner[c]] = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            chan_state_t          r_state;
            chan_state_t          w_state_next;
            logic [IDX_W-1:0]     r_owner;
            logic [ADDR_BITS-1:0] r_addr;
            logic [DATA_BITS-1:0] r_data;
            logic [CONSUMERS-1:0] w_excl_in;
            logic [CONSUMERS-1:0] w_excl_out;
            logic                 w_found;
            logic [IDX_W-1:0]     w_idx;
            logic                 w_take;

            // Lower-index channels claim first within a cycle.
            if (gi == 0) begin : g_head
                assign w_excl_in = w_owned;
            end else begin : g_tail
                assign w_excl_in = g_chan[gi-1].w_excl_out;
            end

            mem_rr_picker #(
                .N  (CONSUMERS),
                .IW (IDX_W)
            ) u_picker (
                .i_req   (w_any_req),
                .i_excl  (w_excl_in),
                .i_ptr   (r_rr_ptr),
                .o_found (w_found),
                .o_idx   (w_idx)
            );

            assign w_take     = (r_state == IDLE) && w_found;
            assign w_excl_out = w_excl_in | (w_take ? (CONSUMERS'(1) << w_idx) : '0);

            always_comb begin
                w_state_next = r_state;
                case (r_state)
                    IDLE: begin
`ifdef MEM_ARB_WRITE_EN
                        if (w_take) w_state_next = consumer_read_valid[w_idx] ? RD_WAIT : WR_WAIT;
`else
                        if (w_take) w_state_next = RD_WAIT;
`endif
                    end
                    RD_WAIT:  if (mem_read_ready[gi]) w_state_next = RD_RELAY;
                    RD_RELAY: if (!consumer_read_valid[r_owner]) w_state_next = IDLE;
`ifdef MEM_ARB_WRITE_EN
                    WR_WAIT:  if (mem_write_ready[gi]) w_state_next = WR_RELAY;
                    WR_RELAY: if (!consumer_write_valid[r_owner]) w_state_next = IDLE;
`endif
                    default:  w_state_next = IDLE;
                endcase
            end

            // r_data carries write data out, or read data back to the owner.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state <= IDLE;
                    r_owner <= '0;
                    r_addr  <= '0;
                    r_data  <= '0;
                end else begin
                    r_state <= w_state_next;
                    if (w_take) begin
                        r_owner <= w_idx;
`ifdef MEM_ARB_WRITE_EN
                        if (consumer_read_valid[w_idx]) begin
                            r_addr <= consumer_read_address[w_idx];
                        end else begin
                            r_addr <= consumer_write_address[w_idx];
                            r_data <= consumer_write_data[w_idx];
                        end
`else
                        r_addr <= consumer_read_address[w_idx];
`endif
                    end else if ((r_state == RD_WAIT) && mem_read_ready[gi]) begin
                        r_data <= mem_read_data[gi];
                    end
                end
            end

            assign mem_read_valid[gi]   = (r_state == RD_WAIT);
            assign mem_read_address[gi] = (r_state == RD_WAIT) ? r_addr : '0;
`ifdef MEM_ARB_WRITE_EN
            assign mem_write_valid[gi]   = (r_state == WR_WAIT);
            assign mem_write_address[gi] = (r_state == WR_WAIT) ? r_addr : '0;
            assign mem_write_data[gi]    = (r_state == WR_WAIT) ? r_data : '0;
            assign w_wr_relay[gi]        = (r_state == WR_RELAY);
`endif
            assign w_busy[gi]      = (r_state != IDLE);
            assign w_rd_relay[gi]  = (r_state == RD_RELAY);
            assign w_owner[gi]     = r_owner;
            assign w_rdata[gi]     = r_data;
            assign w_grant[gi]     = w_take;
            assign w_grant_idx[gi] = w_idx;
        end
    endgenerate

    always_comb begin
        consumer_read_ready  = '0;
        consumer_read_data   = '0;
        consumer_write_ready = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_rd_relay[c]) begin
                consumer_read_ready[w_owner[c]] = 1'b1;
                consumer_read_data[w_owner[c]]  = w_rdata[c];
            end
`ifdef MEM_ARB_WRITE_EN
            if (w_wr_relay[c]) consumer_write_ready[w_owner[c]] = 1'b1;
`endif
        end
    end

    // The highest granting channel holds the latest scan position.
    always_comb begin
        w_ptr_next = r_rr_ptr;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_grant[c]) begin
                w_ptr_next = (w_grant_idx[c] == IDX_W'(CONSUMERS - 1)) ? '0
                           : (w_grant_idx[c] + IDX_W'(1));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rr_ptr <= '0;
        else       r_rr_ptr <= w_ptr_next;
    end

    assign busy = |w_busy;

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed bench: one single-channel and one dual-channel arbiter, bench-side memory models.
module tb_mem_channel_arbiter;

    localparam int AB = 8;
    localparam int DB = 16;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Single-channel instance
    logic [NC-1:0]         c1_rv = '0, c1_wv = '0;
    logic [NC-1:0]         c1_rr, c1_wr;
    logic [NC-1:0][AB-1:0] c1_ra = '0, c1_wa = '0;
    logic [NC-1:0][DB-1:0] c1_wd = '0;
    logic [NC-1:0][DB-1:0] c1_rd;
    logic [0:0]            m1_rv, m1_wv;
    logic [0:0]            m1_rr = '0, m1_wr = '0;
    logic [0:0][AB-1:0]    m1_ra, m1_wa;
    logic [0:0][DB-1:0]    m1_rd = '0;
    logic [0:0][DB-1:0]    m1_wd;
    logic                  busy1;

    // Dual-channel instance
    logic [NC-1:0]         c2_rv = '0;
    logic [NC-1:0]         c2_wv = '0;
    logic [NC-1:0]         c2_rr, c2_wr;
    logic [NC-1:0][AB-1:0] c2_ra = '0, c2_wa = '0;
    logic [NC-1:0][DB-1:0] c2_wd = '0;
    logic [NC-1:0][DB-1:0] c2_rd;
    logic [1:0]            m2_rv, m2_wv;
    logic [1:0]            m2_rr = '0, m2_wr = '0;
    logic [1:0][AB-1:0]    m2_ra, m2_wa;
    logic [1:0][DB-1:0]    m2_rd = '0;
    logic [1:0][DB-1:0]    m2_wd;
    logic                  busy2;

    logic unused_sink;
    assign unused_sink = ^{m1_wa, m1_wd, m2_wv, m2_wa, m2_wd, c2_wr};

    mem_channel_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .CONSUMERS(NC), .CHANNELS(1)) u_dut1 (
        .clk(clk), .reset(rst),
        .consumer_read_valid(c1_rv), .consumer_read_address(c1_ra),
        .consumer_read_ready(c1_rr), .consumer_read_data(c1_rd),
        .consumer_write_valid(c1_wv), .consumer_write_address(c1_wa),
        .consumer_write_data(c1_wd), .consumer_write_ready(c1_wr),
        .mem_read_valid(m1_rv), .mem_read_address(m1_ra),
        .mem_read_ready(m1_rr), .mem_read_data(m1_rd),
        .mem_write_valid(m1_wv), .mem_write_address(m1_wa),
        .mem_write_data(m1_wd), .mem_write_ready(m1_wr),
        .busy(busy1)
    );

    mem_channel_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .CONSUMERS(NC), .CHANNELS(2)) u_dut2 (
        .clk(clk), .reset(rst),
        .consumer_read_valid(c2_rv), .consumer_read_address(c2_ra),
        .consumer_read_ready(c2_rr), .consumer_read_data(c2_rd),
        .consumer_write_valid(c2_wv), .consumer_write_address(c2_wa),
        .consumer_write_data(c2_wd), .consumer_write_ready(c2_wr),
        .mem_read_valid(m2_rv), .mem_read_address(m2_ra),
        .mem_read_ready(m2_rr), .mem_read_data(m2_rd),
        .mem_write_valid(m2_wv), .mem_write_address(m2_wa),
        .mem_write_data(m2_wd), .mem_write_ready(m2_wr),
        .busy(busy2)
    );

    function automatic logic [DB-1:0] mem_val(input logic [AB-1:0] a);
        return (a == 8'h10) ? 16'h1234 : {8'hC0, a};
    endfunction

    // Memory model for the single-channel DUT: ready after m1_wait cycles of valid.
    int   m1_wait  = 0;
    int   m1_rcnt  = 0;
    int   m1_wcnt  = 0;
    logic m1_force = 1'b0;
    always @(negedge clk) begin
        if (m1_rv[0]) begin
            m1_rr[0] = (m1_rcnt >= m1_wait);
            m1_rd[0] = mem_val(m1_ra[0]);
            m1_rcnt++;
        end else begin
            m1_rr[0] = 1'b0;
            m1_rcnt  = 0;
        end
        m1_rr[0] = m1_rr[0] | m1_force;
        if (m1_wv[0]) begin
            m1_wr[0] = (m1_wcnt >= m1_wait);
            m1_wcnt++;
        end else begin
            m1_wr[0] = 1'b0;
            m1_wcnt  = 0;
        end
    end

    // Zero-wait read memory for the dual-channel DUT.
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            m2_rr[c] = m2_rv[c];
            m2_rd[c] = mem_val(m2_ra[c]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        c1_rv = '0; c1_wv = '0; c2_rv = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_mrv",   32'(m1_rv), 32'h0);
        chk("rst_busy1", 32'(busy1), 32'h0);
        chk("rst_crr",   32'(c1_rr), 32'h0);
        chk("rst_mrv2",  32'(m2_rv), 32'h0);
        chk("rst_busy2", 32'(busy2), 32'h0);

        // T1: C0 reads 0x10, memory answers one cycle after valid
        m1_wait = 1;
        do_reset();
        c1_ra[0] = 8'h10; c1_rv[0] = 1'b1;
        tick();
        chk("t1_mrv_c1",  32'(m1_rv),    32'h1);
        chk("t1_maddr",   32'(m1_ra[0]), 32'h10);
        chk("t1_busy",    32'(busy1),    32'h1);
        chk("t1_crr_c1",  32'(c1_rr),    32'h0);
        tick();
        chk("t1_mrv_c2",  32'(m1_rv),    32'h1);
        chk("t1_crr_c2",  32'(c1_rr),    32'h0);
        tick();
        chk("t1_crr_c3",  32'(c1_rr),    32'h1);
        chk("t1_data",    32'(c1_rd[0]), 32'h1234);
        chk("t1_mrv_c3",  32'(m1_rv),    32'h0);
        tick();
        chk("t1_hold",    32'(c1_rr),    32'h1);
        c1_rv[0] = 1'b0;
        tick();
        chk("t1_idle_rr",   32'(c1_rr),    32'h0);
        chk("t1_idle_busy", 32'(busy1),    32'h0);
        chk("t1_idle_data", 32'(c1_rd[0]), 32'h0);
        $display("t1: C0 read 0x10 done");

        // T2: C1 and C3 at rr_ptr=0, zero-wait memory; C1 re-requests behind C3
        m1_wait = 0;
        do_reset();
        c1_ra[1] = 8'h21; c1_ra[3] = 8'h23; c1_rv = 4'b1010;
        tick();
        chk("t2_first_addr", 32'(m1_ra[0]), 32'h21);
        tick();
        chk("t2_c1_ready",   32'(c1_rr),    32'h2);
        chk("t2_c1_data",    32'(c1_rd[1]), 32'hC021);
        c1_rv[1] = 1'b0;
        tick();
        chk("t2_gap_busy",   32'(busy1),    32'h0);
        c1_rv[1] = 1'b1;
        tick();
        chk("t2_second_addr", 32'(m1_ra[0]), 32'h23);
        tick();
        chk("t2_c3_ready",   32'(c1_rr),    32'h8);
        chk("t2_c3_data",    32'(c1_rd[3]), 32'hC023);
        c1_rv[3] = 1'b0;
        tick();
        tick();
        chk("t2_third_addr", 32'(m1_ra[0]), 32'h21);
        tick();
        chk("t2_c1_again",   32'(c1_rr),    32'h2);
        c1_rv[1] = 1'b0;
        tick();
        $display("t2: C1, C3, C1 served in order");

        // T3: two channels, all four consumers read at once
        do_reset();
        for (int j = 0; j < NC; j++) c2_ra[j] = 8'(8'h30 + j);
        c2_rv = 4'b1111;
        tick();
        chk("t3_mrv_both", 32'(m2_rv),    32'h3);
        chk("t3_ch0_addr", 32'(m2_ra[0]), 32'h30);
        chk("t3_ch1_addr", 32'(m2_ra[1]), 32'h31);
        tick();
        chk("t3_rdy01",    32'(c2_rr),    32'h3);
        chk("t3_data1",    32'(c2_rd[1]), 32'hC031);
        c2_rv[0] = 1'b0;
        tick();
        chk("t3_mrv_none", 32'(m2_rv),    32'h0);
        tick();
        chk("t3_ch0_c2",   32'(m2_ra[0]), 32'h32);
        chk("t3_ch1_hold", 32'(m2_rv),    32'h1);
        chk("t3_c1_still", 32'(c2_rr),    32'h2);
        c2_rv[1] = 1'b0;
        tick();
        chk("t3_rdy2",     32'(c2_rr),    32'h4);
        c2_rv[2] = 1'b0;
        tick();
        chk("t3_ch1_c3_v", 32'(m2_rv),    32'h2);
        chk("t3_ch1_c3_a", 32'(m2_ra[1]), 32'h33);
        tick();
        chk("t3_rdy3",     32'(c2_rr),    32'h8);
        chk("t3_data3",    32'(c2_rd[3]), 32'hC033);
        c2_rv[3] = 1'b0;
        tick();
        chk("t3_idle",     32'(busy2),    32'h0);
        $display("t3: four reads over two channels done");

`ifdef MEM_ARB_WRITE_EN
        // T4: C2 writes 0xBEEF to 0x05, memory ready after 3 waits
        m1_wait = 3;
        do_reset();
        c1_wa[2] = 8'h05; c1_wd[2] = 16'hBEEF; c1_wv[2] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("t4_mwv",   32'(m1_wv),    32'h1);
            chk("t4_maddr", 32'(m1_wa[0]), 32'h05);
            chk("t4_mdata", 32'(m1_wd[0]), 32'hBEEF);
            chk("t4_cwr",   32'(c1_wr),    32'h0);
        end
        tick();
        chk("t4_mwv_done", 32'(m1_wv), 32'h0);
        chk("t4_cwr_done", 32'(c1_wr), 32'h4);
        c1_wv[2] = 1'b0;
        tick();
        chk("t4_cwr_drop", 32'(c1_wr), 32'h0);
        chk("t4_idle",     32'(busy1), 32'h0);
        $display("t4: C2 write 0xBEEF to 0x05 done");
`else
        // T6: write requests are ignored in the read-only build
        do_reset();
        c1_wa[0] = 8'h07; c1_wd[0] = 16'h5A5A; c1_wv[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_mwv",  32'(m1_wv), 32'h0);
            chk("t6_busy", 32'(busy1), 32'h0);
            chk("t6_cwr",  32'(c1_wr), 32'h0);
        end
        c1_wv[0] = 1'b0;
        $display("t6: C0 write ignored");
`endif

        // T5: reset during RD_WAIT, then a late mem_read_ready
        m1_wait = 1000;
        do_reset();
        c1_ra[0] = 8'h44; c1_rv[0] = 1'b1;
        tick();
        chk("t5_pre_mrv", 32'(m1_rv), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("t5_async_mrv",  32'(m1_rv),    32'h0);
        chk("t5_async_addr", 32'(m1_ra[0]), 32'h0);
        chk("t5_async_busy", 32'(busy1),    32'h0);
        c1_rv[0] = 1'b0;
        m1_force = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("t5_late_crr",  32'(c1_rr), 32'h0);
        chk("t5_late_busy", 32'(busy1), 32'h0);
        chk("t5_late_mrv",  32'(m1_rv), 32'h0);
        m1_force = 1'b0;
        $display("t5: reset during RD_WAIT done");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
